// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache arbiter.
// State encoding, rw codes and timer sizing.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int TIMER_W = 4;

endpackage

// File: rtl/cache_arbiter_if.sv
// Requester and cache-side signals of the arbiter.
// slave = arbiter side, master = pipeline/cache side.
interface cache_arbiter_if #(
  parameter int a_width = 8,
  parameter int d_width = 8
);

  logic               req0;
  logic [a_width-1:0] addr0;
  logic               req1;
  logic [a_width-1:0] addr1;
  logic               rw1;
  logic [d_width-1:0] wdata1;
  logic               ack0;
  logic               ack1;
  logic               err0;
  logic               err1;
  logic [d_width-1:0] rdata;
  logic [a_width-1:0] cache_addr;
  logic               cache_rw;
  logic               cache_ce;
  logic [d_width-1:0] cache_wdata;
  logic [d_width-1:0] cache_rdata;
  logic               cache_odv;
  logic               busy;

  modport slave (
    input  req0, addr0, req1, addr1, rw1, wdata1,
    input  cache_rdata, cache_odv,
    output ack0, ack1, err0, err1, rdata,
    output cache_addr, cache_rw, cache_ce,
    output cache_wdata, busy
  );

  modport master (
    output req0, addr0, req1, addr1, rw1, wdata1,
    output cache_rdata, cache_odv,
    input  ack0, ack1, err0, err1, rdata,
    input  cache_addr, cache_rw, cache_ce,
    input  cache_wdata, busy
  );

endinterface

// File: rtl/cache_arbiter_rr_select.sv
// Two-requester round-robin chooser.
// On a tie the port not granted last time wins.
module rr_select (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // pick the winner among the active requests
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    unique case (1'b1)
      (req0 && req1):  gnt_id = ~last_grant;
      (req1 && !req0): gnt_id = 1'b1;
      default:         gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache between fetch (port 0) and data (port 1).
// One transaction at a time, round-robin on contention, timeout abort.
module cache_arbiter #(
  parameter int a_width = 8,
  parameter int d_width = 8,
  parameter int timeout = 15
) (
  input logic            clk,
  input logic            clr,
  cache_arbiter_if.slave bus
);

  import cache_ctrl_pkg::*;

  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(timeout - 1);

  state_t               state;
  logic                 last_grant;
  logic                 gnt_q;
  logic [TIMER_W-1:0]   timer;
  logic [a_width-1:0]   addr_q;
  logic                 rw_q;
  logic                 ce_q;
  logic [d_width-1:0]   wdata_q;
  logic [d_width-1:0]   rdata_q;
  logic                 ack0_q;
  logic                 ack1_q;
  logic                 err0_q;
  logic                 err1_q;
  logic                 gnt_valid;
  logic                 gnt_id;

  rr_select u_rr (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // transaction FSM with registered cache and handshake outputs
  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      timer      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      ce_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt_q   <= gnt_id;
            addr_q  <= gnt_id ? bus.addr1 : bus.addr0;
            rw_q    <= gnt_id ? bus.rw1 : RW_READ;
            wdata_q <= gnt_id ? bus.wdata1 : '0;
            ce_q    <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.cache_odv) begin
            if (rw_q == RW_READ) rdata_q <= bus.cache_rdata;
            ce_q       <= 1'b0;
            ack0_q     <= ~gnt_q;
            ack1_q     <= gnt_q;
            last_grant <= gnt_q;
            state      <= ST_DONE;
          end else if (timer == T_LAST) begin
            ce_q       <= 1'b0;
            err0_q     <= ~gnt_q;
            err1_q     <= gnt_q;
            last_grant <= gnt_q;
            state      <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.err0        = err0_q;
  assign bus.err1        = err1_q;
  assign bus.rdata       = rdata_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_rw    = rw_q;
  assign bus.cache_ce    = ce_q;
  assign bus.cache_wdata = wdata_q;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus random
// transactions against a transaction-level reference model.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter_if #(.a_width(8), .d_width(8)) bus ();

  cache_arbiter #(
    .a_width (8),
    .d_width (8),
    .timeout (15)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  int cnt      = 0;
  int last_port = 1;
  logic       mem_init = 1'b0;
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata = 8'h00;

  // free-running cycle count
  always @(posedge clk) cyc <= cyc + 1;

  // cache model: odv after lat cycles of ce, lat=0 never answers
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB7;
      mem_init <= 1'b1;
    end
    if (!clr || !bus.cache_ce) begin
      cnt           <= 0;
      bus.cache_odv <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      if (!bus.cache_odv && cnt + 1 == lat) begin
        bus.cache_odv <= 1'b1;
        if (bus.cache_rw) bus.cache_rdata <= mem[bus.cache_addr];
        else mem[bus.cache_addr] <= bus.cache_wdata;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drop_all();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    int got;
    clr = 1'b0;
    bus.req0 = 1'b1;  bus.addr0 = 8'h33;
    bus.req1 = 1'b0;  bus.addr1 = 8'h44;
    bus.rw1 = 1'b1;   bus.wdata1 = 8'h99;
    tick(); tick();
    n_checks++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy,
         bus.cache_ce, bus.cache_rw} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 0", {bus.ack0, bus.ack1,
               bus.err0, bus.err1, bus.busy, bus.cache_ce, bus.cache_rw});
    end
    n_checks++;
    if ({bus.rdata, bus.cache_addr, bus.cache_wdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0",
               {bus.rdata, bus.cache_addr, bus.cache_wdata});
    end
    lat = 1;
    bus.req1 = 1'b1;
    clr = 1'b1;
    got = -1;
    for (int i = 0; i < 20 && got < 0; i++) begin
      tick();
      if (bus.ack0) got = 0;
      else if (bus.ack1) got = 1;
    end
    drop_all();
    n_checks++;
    if (got !== 0) begin
      n_fail++;
      $display("FAIL reset_first_grant got %0d want 0", got);
    end
    last_port = 0;
    exp_rdata = ref_mem[8'h33];
    repeat (3) tick();
  endtask

  task automatic test_read_hit();
    int t0, t;
    lat = 1;
    bus.addr0 = 8'h12;
    bus.req0 = 1'b1;
    t0 = cyc;
    tick();
    n_checks++;
    if ({bus.cache_ce, bus.cache_rw, bus.cache_addr} !== {2'b11, 8'h12}) begin
      n_fail++;
      $display("FAIL hit_issue got %h want %h",
               {bus.cache_ce, bus.cache_rw, bus.cache_addr}, {2'b11, 8'h12});
    end
    for (int i = 0; i < 30 && !bus.ack0; i++) tick();
    t = bus.ack0 ? cyc - t0 : -1;
    drop_all();
    n_checks++;
    if (t !== 3) begin
      n_fail++;
      $display("FAIL hit_latency got %0d want 3", t);
    end
    n_checks++;
    if (bus.rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL hit_rdata got %h want a5", bus.rdata);
    end
    exp_rdata = 8'hA5;
    last_port = 0;
    repeat (3) tick();
  endtask

  task automatic test_write_miss();
    int t0, ack_t, nack, bad;
    logic ce_at_ack;
    lat = 8;
    bus.addr1 = 8'h40; bus.wdata1 = 8'h3C; bus.rw1 = 1'b0;
    bus.req1 = 1'b1;
    t0 = cyc; ack_t = -1; nack = 0; bad = 0; ce_at_ack = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.cache_ce && ({bus.cache_addr, bus.cache_rw, bus.cache_wdata}
          !== {8'h40, 1'b0, 8'h3C})) bad++;
      if (bus.ack1) begin
        nack++;
        if (ack_t < 0) begin
          ack_t = cyc - t0;
          ce_at_ack = bus.cache_ce;
        end
        drop_all();
      end
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL miss_bus_stable got %0d bad cycles want 0", bad);
    end
    n_checks++;
    if (nack !== 1) begin
      n_fail++;
      $display("FAIL miss_ack_count got %0d want 1", nack);
    end
    n_checks++;
    if (ack_t !== 10) begin
      n_fail++;
      $display("FAIL miss_latency got %0d want 10", ack_t);
    end
    n_checks++;
    if (ce_at_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_ce_drop got %b want 0", ce_at_ack);
    end
    n_checks++;
    if (bus.rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL miss_rdata_hold got %h want %h", bus.rdata, exp_rdata);
    end
    ref_mem[8'h40] = 8'h3C;
    last_port = 1;
    drop_all();
    bus.rw1 = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_contention();
    int got, expp, g;
    lat = 1;
    bus.addr0 = 8'h01; bus.addr1 = 8'h02; bus.rw1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      got = -1;
      for (int i = 0; i < 30 && got < 0; i++) begin
        tick();
        if (bus.ack0) got = 0;
        else if (bus.ack1) got = 1;
      end
      expp = 1 - last_port;
      n_checks++;
      if (got !== expp) begin
        n_fail++;
        $display("FAIL rr_grant_%0d got %0d want %0d", n, got, expp);
      end
      last_port = expp;
      exp_rdata = ref_mem[expp == 1 ? 8'h02 : 8'h01];
      n_checks++;
      if (bus.rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rr_rdata_%0d got %h want %h", n, bus.rdata, exp_rdata);
      end
      if (n == 3) drop_all();
      else begin
        g = 0;
        for (int i = 0; i < 10 && !bus.cache_ce; i++) begin
          tick();
          g++;
        end
        n_checks++;
        if (g !== 2) begin
          n_fail++;
          $display("FAIL rr_gap_%0d got %0d want 2", n, g);
        end
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int t0, et, stray;
    logic idle;
    lat = 0;
    bus.addr1 = 8'h77; bus.rw1 = 1'b1;
    bus.req1 = 1'b1;
    t0 = cyc; stray = 0;
    for (int i = 0; i < 40 && !bus.err1; i++) begin
      tick();
      if (bus.ack0 || bus.ack1 || bus.err0) stray++;
    end
    et = bus.err1 ? cyc - t0 : -1;
    drop_all();
    tick();
    idle = !bus.busy;
    repeat (5) begin
      tick();
      if (bus.ack0 || bus.ack1 || bus.err0 || bus.err1) stray++;
    end
    n_checks++;
    if (et !== 17) begin
      n_fail++;
      $display("FAIL timeout_latency got %0d want 17", et);
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL timeout_stray got %0d want 0", stray);
    end
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_idle got %b want 1", idle);
    end
    n_checks++;
    if (bus.rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL timeout_rdata got %h want %h", bus.rdata, exp_rdata);
    end
    last_port = 1;
  endtask

  task automatic test_reset_mid_wait();
    lat = 0;
    bus.addr0 = 8'h55;
    bus.req0 = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({bus.busy, bus.cache_ce} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_in_wait got %b want 11", {bus.busy, bus.cache_ce});
    end
    clr = 1'b0;
    tick();
    n_checks++;
    if ({bus.cache_ce, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy,
         bus.rdata} !== 14'h0) begin
      n_fail++;
      $display("FAIL midrst_state got %h want 0", {bus.cache_ce, bus.ack0,
               bus.ack1, bus.err0, bus.err1, bus.busy, bus.rdata});
    end
    drop_all();
    clr = 1'b1;
    exp_rdata = 8'h00;
    last_port = 1;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int pat, r, L, win, t0, t, expt;
    logic [7:0] a0, a1, w, waddr;
    logic rw, wrw, ok;
    logic [3:0] vec, expv;
    for (int n = 0; n < 40; n++) begin
      pat = $urandom_range(1, 3);
      a0 = 8'($urandom); a1 = 8'($urandom); w = 8'($urandom);
      rw = 1'($urandom);
      r = $urandom_range(0, 9);
      L = (r < 2) ? 20 : (r == 2) ? 15 : $urandom_range(1, 14);
      win = (pat == 1) ? 0 : (pat == 2) ? 1 : 1 - last_port;
      waddr = win ? a1 : a0;
      wrw = win ? rw : 1'b1;
      ok = (L <= 15);
      expt = ok ? L + 2 : 17;
      expv = ok ? (win ? 4'b0100 : 4'b1000) : (win ? 4'b0001 : 4'b0010);
      lat = L;
      bus.addr0 = a0; bus.addr1 = a1; bus.wdata1 = w; bus.rw1 = rw;
      bus.req0 = (pat != 2); bus.req1 = (pat != 1);
      t0 = cyc;
      tick();
      n_checks++;
      if ({bus.cache_ce, bus.cache_addr, bus.cache_rw,
           (bus.cache_rw ? 8'h00 : bus.cache_wdata)} !==
          {1'b1, waddr, wrw, (wrw ? 8'h00 : w)}) begin
        n_fail++;
        $display("FAIL rnd_issue_%0d got %h want %h", n,
                 {bus.cache_ce, bus.cache_addr, bus.cache_rw, bus.cache_wdata},
                 {1'b1, waddr, wrw, w});
      end
      vec = 4'b0;
      for (int i = 0; i < 40 && vec == 4'b0; i++) begin
        tick();
        vec = {bus.ack0, bus.ack1, bus.err0, bus.err1};
      end
      t = (vec != 4'b0) ? cyc - t0 : -1;
      drop_all();
      if (ok) begin
        if (wrw) exp_rdata = ref_mem[waddr];
        else ref_mem[waddr] = w;
      end
      last_port = win;
      n_checks++;
      if (vec !== expv) begin
        n_fail++;
        $display("FAIL rnd_resp_%0d got %b want %b", n, vec, expv);
      end
      n_checks++;
      if (t !== expt) begin
        n_fail++;
        $display("FAIL rnd_latency_%0d got %0d want %0d", n, t, expt);
      end
      n_checks++;
      if (bus.rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rnd_rdata_%0d got %h want %h", n, bus.rdata, exp_rdata);
      end
      repeat (2) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hB7;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00;
    bus.rw1 = 1'b1; bus.wdata1 = 8'h00;
    test_reset();
    test_read_hit();
    test_write_miss();
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
